vga_timing_gen: RTL

- Parametrised successor to the fixed 640x480 sync generator.
- Generates horizontal and vertical sync, display-enable, pixel coordinates, and line/frame start strobes for the connect-four renderer.
- All front porch, sync, back porch, active and polarity values are parameters.
- An internal clock-enable divider lets the block run from a fast system clock.
- All outputs are registered and mutually aligned. The H and V totals are exact, with no off-by-one.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_timing_gen_pixel_ce_gen.sv | 29 ++
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers.
// Holds the 640x480@60 defaults and an 800x600 set.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = 525;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_H_TOTAL  = 1056;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam int SVGA_V_TOTAL  = 628;

  function automatic logic sync_active(
    input int cnt,
    input int start,
    input int width
  );
    return (cnt >= start) &&
           (cnt < start + width);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_ce_gen.sv
// Pixel clock-enable divider.
// adv fires on the last clk of a pixel; div_zero on the first.
module pixel_ce_gen #(
  parameter int CE_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic adv,
  output logic div_zero
);

  localparam int DW =
    (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  always_comb begin
    adv      = (div_q == DW'(CE_DIV - 1));
    div_zero = (div_q == '0);
    div_d    = adv ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator, registered outputs.
// Define VGA_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CE_DIV   = 1,
  localparam int  H_TOTAL  =
    H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  =
    V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW = $clog2(H_TOTAL),
  localparam int  YW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          inDisplayArea,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          pix_ce,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  logic adv;
  logic div_zero;

  pixel_ce_gen #(
    .CE_DIV(CE_DIV)
  ) u_ce (
    .clk     (clk),
    .reset   (reset),
    .adv     (adv),
    .div_zero(div_zero)
  );

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_q == XW'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == YW'(V_TOTAL - 1)) v_d = '0;
        else v_d = v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Output stage: one clk behind the counters.
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic          ce_q, ce_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  always_comb begin
    hs_d = sync_active(int'(h_q),
      H_ACTIVE + H_FP, H_SYNC) ?
      HS_POL : ~HS_POL;
    vs_d = sync_active(int'(v_q),
      V_ACTIVE + V_FP, V_SYNC) ?
      VS_POL : ~VS_POL;
    de_d = (int'(h_q) < H_ACTIVE) &&
           (int'(v_q) < V_ACTIVE);
    px_d = h_q;
    py_d = v_q;
    ce_d = div_zero;
    ls_d = div_zero && (h_q == '0);
    fs_d = ls_d && (v_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      px_q <= '0;
      py_q <= '0;
      ce_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      px_q <= px_d;
      py_q <= py_d;
      ce_q <= ce_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign vga_h_sync    = hs_q;
  assign vga_v_sync    = vs_q;
  assign inDisplayArea = de_q;
  assign pixel_x       = px_q;
  assign pixel_y       = py_q;
  assign pix_ce        = ce_q;
  assign line_start    = ls_q;
  assign frame_start   = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;

  always_comb begin
    fc_d = fs_q ? fc_q + 16'd1 : fc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) fc_q <= '0;
    else       fc_q <= fc_d;
  end

  assign frame_cnt = fc_q;
`endif

endmodule
